// File: rtl/top_module_core_hi_latch.sv
// rtl/top_module_core_hi_latch.sv - WIDTH-wide transparent-high latch with phase-synchronous reset
module hi_latch #(
  parameter int WIDTH = 1
) (
  input  logic             en_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Reset only has an effect while the latch is open; a closed latch ignores it
  always_comb begin
    q_d = rst_i ? '0 : d_i;
  end

  // Intentional level-sensitive storage: follow q_d while enabled, hold while closed
  always_latch begin
    if (en_i) begin
      q_q = q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/top_module_core.sv
// rtl/top_module_core.sv - half-cycle capture cell: high-phase latch and falling-edge register
module top_module_core #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Level-sensitive path: transparent while clock is high, so p closes on the falling edge
  hi_latch #(
    .WIDTH (WIDTH)
  ) u_hi_latch (
    .en_i  (clock),
    .rst_i (reset),
    .d_i   (a),
    .q_o   (p)
  );

  // Edge path: sample a (or clear) on the same falling edge that closes the latch, so p == q in the low phase
  always_ff @(negedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= a;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_top_module_core.sv
// tb/tb_top_module_core.sv - randomized and directed self-checking bench for top_module_core
module tb_top_module_core;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] p;
  logic [W-1:0] q;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic [W-1:0] m_p;
  logic [W-1:0] m_q;
  bit           p_known = 1'b0;
  bit           q_known = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  top_module_core #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .p     (p),
    .q     (q)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: p follows a (or 0 under reset) while clock is high and freezes when it falls;
  // q takes a (or 0 under reset) at each falling edge and nowhere else.
  task automatic drive_clock(input logic v);
    if (clock === 1'b1 && v == 1'b0) begin
      m_q     = reset ? '0 : a;
      q_known = 1'b1;
    end
    clock = v;
    if (v) begin
      m_p     = reset ? '0 : a;
      p_known = 1'b1;
    end
  endtask

  task automatic drive_in(input logic r, input logic [W-1:0] av);
    reset = r;
    a     = av;
    if (clock === 1'b1) begin
      m_p     = reset ? '0 : a;
      p_known = 1'b1;
    end
  endtask

  task automatic settle_and_check(input string tag);
    #1;
    if (p_known) check({tag, ".p"}, p, m_p);
    if (q_known) check({tag, ".q"}, q, m_q);
    if (clock === 1'b0 && p_known && q_known) check({tag, ".inv"}, p, q);
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    a     = '1;
    #2;

    // reset held across a full period with a all ones
    drive_clock(1'b1);       settle_and_check("rst_high");
    drive_clock(1'b0);       settle_and_check("rst_fall");
    drive_in(1'b0, '1);      settle_and_check("rst_release_low");
    drive_clock(1'b1);       settle_and_check("rst_release_high");

    // transparency: p tracks every change in the high phase, q untouched
    drive_in(1'b0, '0);      settle_and_check("transp0");
    drive_in(1'b0, '1);      settle_and_check("transp1");
    drive_in(1'b0, '0);      settle_and_check("transp2");
    drive_in(1'b0, '1);      settle_and_check("transp3");

    // hold: captured at falling edge, low-phase toggles ignored
    drive_clock(1'b0);       settle_and_check("hold_fall");
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b0, (i % 2 == 0) ? 4'h0 : 4'h5);
      settle_and_check("hold_toggle");
    end

    // edge sampling: a high earlier in the phase, low at the falling edge
    drive_clock(1'b1);       settle_and_check("edge_rise");
    drive_in(1'b0, '1);      settle_and_check("edge_a1");
    drive_in(1'b0, '0);      settle_and_check("edge_a0");
    drive_clock(1'b0);       settle_and_check("edge_fall");
    drive_in(1'b0, '1);      settle_and_check("edge_low_a1");
    drive_clock(1'b1);       settle_and_check("edge_next_rise");

    // reset only in the low phase does not touch p
    drive_clock(1'b0);       settle_and_check("lowrst_fall");
    drive_in(1'b1, 4'hA);    settle_and_check("lowrst_assert");
    drive_in(1'b0, 4'h3);    settle_and_check("lowrst_release");
    drive_clock(1'b1);       settle_and_check("lowrst_rise");

    // randomized: clock toggles every 3 bench cycles, inputs change on both bench edges
    begin
      int cyc = 0;
      for (int i = 0; i < 200; i++) begin
        @(posedge tb_clk);
        cyc++;
        if (cyc % 3 == 0) begin
          drive_clock(~clock);
        end else begin
          drive_in($urandom_range(15) == 0, W'($urandom));
        end
        settle_and_check("rand_pos");
        @(negedge tb_clk);
        drive_in($urandom_range(15) == 0, W'($urandom));
        settle_and_check("rand_neg");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
